branch_predictor: RTL and testbench

Parametrised branch target buffer with saturating-counter direction prediction for the 5-stage pipeline CPU. Sits beside the PC register: the IF stage looks up the current PC combinationally and redirects fetch on a predicted-taken hit. The ID stage, where branches resolve, reports each resolved branch back through the update port. Replaces the fixed "predict not-taken, flush on taken" policy with per-entry history.

---
 rtl/branch_predictor.sv | 127 ++++++++++++
 tb/tb_branch_predictor.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters for the IF/ID pipeline.
// Optional statistics counters are built only when the BP_STATS_EN macro is defined.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    input  logic              inv,
    output logic              mispredict,
    input  logic              stat_clr,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_ONE  = 1;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_ONE << (CTR_W - 1);

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [ADDR_W-1:0] r_target [ENTRIES];
    logic [CTR_W-1:0]  r_ctr    [ENTRIES];

    logic [IDX_W-1:0]  w_lk_idx;
    logic [TAG_W-1:0]  w_lk_tag;
    logic [IDX_W-1:0]  w_up_idx;
    logic [TAG_W-1:0]  w_up_tag;
    logic              w_up_hit;
    logic [CTR_W-1:0]  w_up_ctr;

    assign w_lk_idx = lookup_pc[IDX_W+1:2];
    assign w_lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign w_up_idx = upd_pc[IDX_W+1:2];
    assign w_up_tag = upd_pc[ADDR_W-1:IDX_W+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_ctr = r_ctr[w_up_idx];

    // Lookup reads the registered array only, so a same-cycle update is not bypassed.
    assign pred_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign pred_taken  = pred_hit && r_ctr[w_lk_idx][CTR_W-1];
    assign pred_target = pred_hit ? r_target[w_lk_idx] : '0;

    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= '0;
            end
        end else if (inv) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (w_up_hit) begin
                if (upd_taken) begin
                    r_target[w_up_idx] <= upd_target;
                    if (w_up_ctr != CTR_MAX) begin
                        r_ctr[w_up_idx] <= w_up_ctr + CTR_ONE;
                    end
                end else if (w_up_ctr != '0) begin
                    r_ctr[w_up_idx] <= w_up_ctr - CTR_ONE;
                end
            end else if (upd_taken) begin
                // Miss on a taken branch replaces whatever occupied the slot.
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= upd_target;
                r_ctr[w_up_idx]    <= CTR_WEAK;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispred;
    logic        w_unused;

    assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_branches <= '0;
            r_stat_mispred  <= '0;
        end else if (stat_clr) begin
            r_stat_branches <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (upd_valid && (r_stat_branches != 32'hFFFF_FFFF)) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (mispredict && (r_stat_mispred != 32'hFFFF_FFFF)) begin
                r_stat_mispred <= r_stat_mispred + 32'd1;
            end
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_mispred  = r_stat_mispred;
`else
    logic w_unused;

    assign w_unused      = ^{lookup_pc[1:0], upd_pc[1:0], stat_clr};
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: an index/tag array model checked every cycle,
// plus hand-computed literal expectations along the directed sequence.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int ADDR_W  = 32;
    localparam int CTR_W   = 2;
`ifdef BP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_pred_taken;
    logic [ADDR_W-1:0] upd_pred_target;
    logic              inv;
    logic              mispredict;
    logic              stat_clr;
    logic [31:0]       stat_branches;
    logic [31:0]       stat_mispred;

    branch_predictor #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .CTR_W(CTR_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .lookup_pc       (lookup_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .inv             (inv),
        .mispredict      (mispredict),
        .stat_clr        (stat_clr),
        .stat_branches   (stat_branches),
        .stat_mispred    (stat_mispred)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    bit          chk_en   = 1'b0;
    logic [31:0] exp_q[$];

    // model: slot = (pc/4) mod ENTRIES, tag = pc / (4*ENTRIES), counter kept as a plain integer
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_br;
    logic [31:0] m_mis;

    function automatic int slot_of(logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit model_hit(logic [31:0] pc);
        return m_valid[slot_of(pc)] && (m_tag[slot_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit model_mis();
        return upd_valid && ((upd_pred_taken != upd_taken) ||
                             (upd_taken && (upd_pred_target != upd_target)));
    endfunction

    function automatic int min_i(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_i(int a, int b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i]  <= 1'b0;
                m_tag[i]    <= '0;
                m_target[i] <= '0;
                m_ctr[i]    <= 0;
            end
            m_br  <= '0;
            m_mis <= '0;
        end else begin
            if (stat_clr) begin
                m_br  <= '0;
                m_mis <= '0;
            end else begin
                if (upd_valid && (m_br != 32'hFFFF_FFFF)) m_br <= m_br + 1;
                if (model_mis() && (m_mis != 32'hFFFF_FFFF)) m_mis <= m_mis + 1;
            end
            if (inv) begin
                for (int i = 0; i < ENTRIES; i++) m_valid[i] <= 1'b0;
            end else if (upd_valid) begin
                if (model_hit(upd_pc)) begin
                    if (upd_taken) begin
                        m_ctr[slot_of(upd_pc)]    <= min_i(m_ctr[slot_of(upd_pc)] + 1, (1 << CTR_W) - 1);
                        m_target[slot_of(upd_pc)] <= upd_target;
                    end else begin
                        m_ctr[slot_of(upd_pc)] <= max_i(m_ctr[slot_of(upd_pc)] - 1, 0);
                    end
                end else if (upd_taken) begin
                    m_valid[slot_of(upd_pc)]  <= 1'b1;
                    m_tag[slot_of(upd_pc)]    <= tag_of(upd_pc);
                    m_target[slot_of(upd_pc)] <= upd_target;
                    m_ctr[slot_of(upd_pc)]    <= 1 << (CTR_W - 1);
                end
            end
        end
    end

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_noexp"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && reset) begin
            check("cyc_hit", {31'd0, pred_hit}, {31'd0, model_hit(lookup_pc)});
            check("cyc_taken", {31'd0, pred_taken},
                  {31'd0, model_hit(lookup_pc) && (m_ctr[slot_of(lookup_pc)] >= (1 << (CTR_W - 1)))});
            check("cyc_target", pred_target,
                  model_hit(lookup_pc) ? m_target[slot_of(lookup_pc)] : 32'd0);
            check("cyc_mispredict", {31'd0, mispredict}, {31'd0, model_mis()});
            check("cyc_stat_br", stat_branches, STATS ? m_br : 32'd0);
            check("cyc_stat_mis", stat_mispred, STATS ? m_mis : 32'd0);
        end
    end

    // driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
        set_upd(pc, tk, tgt, ptk, ptgt);
        cycle();
        upd_valid = 1'b0;
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic hit,
                        input logic tk, input logic [31:0] tgt);
        lookup_pc = pc;
        #1;
        exp_q.push_back({31'd0, hit});
        lit({name, "_hit"}, {31'd0, pred_hit});
        exp_q.push_back({31'd0, tk});
        lit({name, "_taken"}, {31'd0, pred_taken});
        exp_q.push_back(tgt);
        lit({name, "_target"}, pred_target);
    endtask

    task automatic look_stats(input string name, input logic [31:0] br, input logic [31:0] mis);
        exp_q.push_back(STATS ? br : 32'd0);
        lit({name, "_branches"}, stat_branches);
        exp_q.push_back(STATS ? mis : 32'd0);
        lit({name, "_mispred"}, stat_mispred);
    endtask

    initial begin
        reset           = 1'b1;
        lookup_pc       = 32'h0040_0010;
        upd_valid       = 1'b0;
        upd_pc          = '0;
        upd_taken       = 1'b0;
        upd_target      = '0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = '0;
        inv             = 1'b0;
        stat_clr        = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        cycle();
        chk_en = 1'b1;

        look("cold", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
        look_stats("cold", 32'd0, 32'd0);

        // allocate, mispredicted because the pipe predicted not-taken
        set_upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
        #1;
        exp_q.push_back(32'd1);
        lit("alloc_mispredict", {31'd0, mispredict});
        cycle();
        upd_valid = 1'b0;
        look("alloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);

        // counter 2 -> 3 -> 3 -> 2 -> 1, taken updates also retarget
        upd(32'h0040_0010, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0040);
        upd(32'h0040_0010, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0080);
        upd(32'h0040_0010, 1'b0, 32'h0,         1'b1, 32'h0040_0080);
        upd(32'h0040_0010, 1'b0, 32'h0,         1'b1, 32'h0040_0080);
        look("sat_down", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0080);
        upd(32'h0040_0010, 1'b1, 32'h0040_0080, 1'b0, 32'h0);
        upd(32'h0040_0010, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0080);
        look("sat_up", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0080);
        upd(32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0080);
        look("ctr2", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0080);
        upd(32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0080);
        look("ctr1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0080);

        // alias: same slot, different tag evicts the first branch
        upd(32'h0040_0050, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
        look("alias_old", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
        look("alias_new", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0100);

        // miss not-taken leaves the array alone
        upd(32'h0040_0020, 1'b0, 32'h0, 1'b0, 32'h0);
        look("miss_nt", 32'h0040_0020, 1'b0, 1'b0, 32'h0);

        // same-cycle lookup and allocate: lookup sees pre-edge contents
        lookup_pc = 32'h0040_0030;
        set_upd(32'h0040_0030, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
        look("no_bypass", 32'h0040_0030, 1'b0, 1'b0, 32'h0);
        cycle();
        upd_valid = 1'b0;
        look("after_edge", 32'h0040_0030, 1'b1, 1'b1, 32'h0040_0200);

        // inv beats a simultaneous taken update
        inv = 1'b1;
        upd(32'h0040_0070, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0300);
        inv = 1'b0;
        look("inv_a", 32'h0040_0030, 1'b0, 1'b0, 32'h0);
        look("inv_b", 32'h0040_0070, 1'b0, 1'b0, 32'h0);
        look("inv_c", 32'h0040_0050, 1'b0, 1'b0, 32'h0);

        // statistics: five updates, two with a wrong direction
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        upd(32'h0040_0200, 1'b1, 32'h0040_0300, 1'b0, 32'h0);
        upd(32'h0040_0200, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0300);
        upd(32'h0040_0204, 1'b0, 32'h0,         1'b0, 32'h0);
        upd(32'h0040_0204, 1'b0, 32'h0,         1'b1, 32'h0);
        upd(32'h0040_0208, 1'b1, 32'h0040_0400, 1'b1, 32'h0040_0400);
        look_stats("stats5", 32'd5, 32'd2);
        look("stats_entry", 32'h0040_0200, 1'b1, 1'b1, 32'h0040_0300);

        // clear wins over a same-cycle mispredicted update
        stat_clr = 1'b1;
        upd(32'h0040_020C, 1'b1, 32'h0040_0500, 1'b0, 32'h0);
        stat_clr = 1'b0;
        look_stats("stat_clr", 32'd0, 32'd0);
        upd(32'h0040_020C, 1'b0, 32'h0, 1'b1, 32'h0);
        look_stats("post_clr", 32'd1, 32'd1);

        // asynchronous reset in the middle of an update cycle
        lookup_pc = 32'h0040_0200;
        set_upd(32'h0040_0200, 1'b1, 32'h0040_0600, 1'b0, 32'h0);
        #2 reset = 1'b0;
        #1;
        look("mid_reset", 32'h0040_0200, 1'b0, 1'b0, 32'h0);
        look_stats("mid_reset", 32'd0, 32'd0);
        upd_valid = 1'b0;
        #1 reset = 1'b1;
        cycle();
        look("post_reset", 32'h0040_0200, 1'b0, 1'b0, 32'h0);
        look_stats("post_reset", 32'd0, 32'd0);

        // back-to-back updates, each building on the last
        upd(32'h0040_0404, 1'b1, 32'h0040_0800, 1'b0, 32'h0);
        upd(32'h0040_0404, 1'b0, 32'h0,         1'b1, 32'h0040_0800);
        upd(32'h0040_0404, 1'b1, 32'h0040_0900, 1'b0, 32'h0);
        upd(32'h0040_0404, 1'b1, 32'h0040_0900, 1'b1, 32'h0040_0900);
        look("b2b", 32'h0040_0404, 1'b1, 1'b1, 32'h0040_0900);
        repeat (2) cycle();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
